sc_btn_debounce_pulse: RTL and testbench

- Upstream conditioner for the SC register/counter stage of the board design.
- Takes a raw, bouncing, active-low board pushbutton and synchronizes it to CLOCK_50.
- Debounces it with a counter-based FSM and emits one-cycle increment/enable pulses that drive the counter's increment input directly.
- Optional auto-repeat produces periodic pulses while the button is held.

---
 rtl/sc_btn_pkg.sv | 15 +
 rtl/sc_btn_debounce_pulse_if.sv | 27 ++
 rtl/sc_sync_2ff.sv | 27 ++
 rtl/sc_btn_debounce_pulse.sv | 127 ++++++++++++
 tb/tb_sc_btn_debounce_pulse.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sc_btn_pkg.sv
// Shared types and constants for the SC pushbutton conditioner.
// Imported by the debounce top and any board-input helpers.
package sc_btn_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'b00,
    PRESS_CHK   = 2'b01,
    HELD        = 2'b10,
    RELEASE_CHK = 2'b11
  } btn_state_e;

  localparam int DEBOUNCE_10MS_50MHZ = 500000;
  localparam int CNT_W_DEFAULT       = 24;

endpackage

// File: rtl/sc_btn_debounce_pulse_if.sv
// Button conditioner bundle: raw button and gate in,
// pulse, debounced level and debug state out.
interface sc_btn_debounce_pulse_if;

  logic       button_n;
  logic       enable;
  logic       pulse;
  logic       level;
  logic [1:0] state;

  modport master (
    output button_n,
    output enable,
    input  pulse,
    input  level,
    input  state
  );

  modport slave (
    input  button_n,
    input  enable,
    output pulse,
    output level,
    output state
  );

endinterface

// File: rtl/sc_sync_2ff.sv
// Two-flop synchronizer for asynchronous board inputs.
// Both flops reset to RST_VAL so a released level is seen at reset.
module sc_sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/sc_btn_debounce_pulse.sv
// Debounces an active-low pushbutton and emits one-cycle
// increment pulses, with optional auto-repeat while held.
module sc_btn_debounce_pulse
  import sc_btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS_50MHZ,
  parameter int REPEAT_PERIOD   = 0,
  parameter int CNT_W           = CNT_W_DEFAULT
) (
  input  logic       SC_BtnDEBOUNCE_CLOCK_50,
  input  logic       SC_BtnDEBOUNCE_RESET_InLow,
  input  logic       SC_BtnDEBOUNCE_button_InLow,
  input  logic       SC_BtnDEBOUNCE_enable_InHigh,
  output logic       SC_BtnDEBOUNCE_pulse_OutHigh,
  output logic       SC_BtnDEBOUNCE_level_OutHigh,
  output logic [1:0] SC_BtnDEBOUNCE_state_OutBUS
);

  localparam logic [CNT_W-1:0] DB_LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RP_LAST =
    CNT_W'((REPEAT_PERIOD > 0) ? REPEAT_PERIOD - 1 : 0);
  localparam bit RP_EN = (REPEAT_PERIOD > 0);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic clk;
  logic rst_n;
  logic sync_n;
  logic sync_pressed;
  logic fire;

  btn_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;
  logic             level_q, level_d;

  assign clk   = SC_BtnDEBOUNCE_CLOCK_50;
  assign rst_n = SC_BtnDEBOUNCE_RESET_InLow;

  sc_sync_2ff #(
    .RST_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (SC_BtnDEBOUNCE_button_InLow),
    .q     (sync_n)
  );

  assign sync_pressed = ~sync_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      level_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      level_q <= level_d;
    end
  end

  // One shared counter times both debounce windows and repeats.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fire    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sync_pressed) begin
          state_d = PRESS_CHK;
          cnt_d   = '0;
        end
      end
      PRESS_CHK: begin
        if (!sync_pressed) begin
          state_d = IDLE;
        end else if (cnt_q == DB_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
          fire    = 1'b1;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      HELD: begin
        if (!sync_pressed) begin
          state_d = RELEASE_CHK;
          cnt_d   = '0;
        end else if (RP_EN) begin
          if (cnt_q == RP_LAST) begin
            fire  = 1'b1;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end else begin
          cnt_d = '0;
        end
      end
      RELEASE_CHK: begin
        if (sync_pressed) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    pulse_d = fire & SC_BtnDEBOUNCE_enable_InHigh;
    level_d = (state_d == HELD) || (state_d == RELEASE_CHK);
  end

  assign SC_BtnDEBOUNCE_pulse_OutHigh = pulse_q;
  assign SC_BtnDEBOUNCE_level_OutHigh = level_q;
  assign SC_BtnDEBOUNCE_state_OutBUS  = state_q;

endmodule

// File: tb/tb_sc_btn_debounce_pulse.sv
// Bench for sc_btn_debounce_pulse: run-length reference model,
// queued expectations and a separate negedge monitor.
module tb_sc_btn_debounce_pulse;

  localparam int D    = 4;
  localparam int RP_B = 6;

  typedef struct packed {
    logic       p;
    logic       l;
    logic [1:0] s;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n;
  logic btn;
  logic en;

  always #5 clk = ~clk;

  sc_btn_debounce_pulse_if if_a ();
  sc_btn_debounce_pulse_if if_b ();

  assign if_a.button_n = btn;
  assign if_a.enable   = en;
  assign if_b.button_n = btn;
  assign if_b.enable   = en;

  sc_btn_debounce_pulse #(
    .DEBOUNCE_CYCLES (D),
    .REPEAT_PERIOD   (0),
    .CNT_W           (8)
  ) u_dut_a (
    .SC_BtnDEBOUNCE_CLOCK_50      (clk),
    .SC_BtnDEBOUNCE_RESET_InLow   (rst_n),
    .SC_BtnDEBOUNCE_button_InLow  (if_a.button_n),
    .SC_BtnDEBOUNCE_enable_InHigh (if_a.enable),
    .SC_BtnDEBOUNCE_pulse_OutHigh (if_a.pulse),
    .SC_BtnDEBOUNCE_level_OutHigh (if_a.level),
    .SC_BtnDEBOUNCE_state_OutBUS  (if_a.state)
  );

  sc_btn_debounce_pulse #(
    .DEBOUNCE_CYCLES (D),
    .REPEAT_PERIOD   (RP_B),
    .CNT_W           (8)
  ) u_dut_b (
    .SC_BtnDEBOUNCE_CLOCK_50      (clk),
    .SC_BtnDEBOUNCE_RESET_InLow   (rst_n),
    .SC_BtnDEBOUNCE_button_InLow  (if_b.button_n),
    .SC_BtnDEBOUNCE_enable_InHigh (if_b.enable),
    .SC_BtnDEBOUNCE_pulse_OutHigh (if_b.pulse),
    .SC_BtnDEBOUNCE_level_OutHigh (if_b.level),
    .SC_BtnDEBOUNCE_state_OutBUS  (if_b.state)
  );

  obs_t  qa[$];
  obs_t  qb[$];
  string xn[$];
  int    xa[$];
  int    xe[$];

  int ntests = 0;
  int nfail  = 0;
  int pa     = 0;
  int pb     = 0;

  // Model: a level flips once the opposite synced value has
  // been seen on D+1 consecutive edges.
  int rp[2]   = '{0, RP_B};
  int prun[2];
  int rrun[2];
  int rep[2];
  bit lvl[2];
  bit h1, h2;

  function automatic logic [1:0] mstate(bit l, int rr, int pr);
    if (l) return (rr > 0) ? 2'b11 : 2'b10;
    return (pr > 0) ? 2'b01 : 2'b00;
  endfunction

  initial begin
    bit   sp;
    bit   pl;
    obs_t o;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        h1 = 1'b1;
        h2 = 1'b1;
        for (int m = 0; m < 2; m++) begin
          prun[m] = 0;
          rrun[m] = 0;
          rep[m]  = 0;
          lvl[m]  = 1'b0;
        end
        qa.delete();
        qb.delete();
      end else begin
        sp = !h2;
        h2 = h1;
        h1 = btn;
        for (int m = 0; m < 2; m++) begin
          pl = 1'b0;
          if (!lvl[m]) begin
            if (sp) begin
              prun[m]++;
              if (prun[m] == D + 1) begin
                lvl[m]  = 1'b1;
                prun[m] = 0;
                rrun[m] = 0;
                rep[m]  = 0;
                pl      = 1'b1;
              end
            end else begin
              prun[m] = 0;
            end
          end else if (!sp) begin
            rrun[m]++;
            if (rrun[m] == D + 1) begin
              lvl[m]  = 1'b0;
              rrun[m] = 0;
            end
          end else if (rrun[m] > 0) begin
            rrun[m] = 0;
            rep[m]  = 0;
          end else if (rp[m] > 0) begin
            rep[m]++;
            if (rep[m] == rp[m]) begin
              rep[m] = 0;
              pl     = 1'b1;
            end
          end
          o.p = pl & en;
          o.l = lvl[m];
          o.s = mstate(lvl[m], rrun[m], prun[m]);
          if (m == 0) qa.push_back(o);
          else qb.push_back(o);
        end
      end
    end
  end

  task automatic check(string nm, int act, int exp);
    ntests++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s got=%0h want=%0h @%0t",
               nm, act, exp, $time);
    end
  endtask

  initial begin
    obs_t e;
    obs_t g;
    forever begin
      @(negedge clk);
      while (xn.size() > 0)
        check(xn.pop_front(), xa.pop_front(), xe.pop_front());
      if (rst_n) begin
        if (qa.size() > 0) begin
          e = qa.pop_front();
          g = {if_a.pulse, if_a.level, if_a.state};
          check("dut_a_outputs", int'(g), int'(e));
        end
        if (qb.size() > 0) begin
          e = qb.pop_front();
          g = {if_b.pulse, if_b.level, if_b.state};
          check("dut_b_outputs", int'(g), int'(e));
        end
        pa += int'(if_a.pulse);
        pb += int'(if_b.pulse);
      end
    end
  end

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic hold(bit b, int n);
    btn = b;
    cyc(n);
  endtask

  task automatic post(string nm, int act, int exp);
    xn.push_back(nm);
    xa.push_back(act);
    xe.push_back(exp);
  endtask

  initial begin
    int sa;
    int sb;
    rst_n = 1'b0;
    btn   = 1'b1;
    en    = 1'b1;
    cyc(3);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(2);

    sa = pa; sb = pb;
    hold(1'b0, 20);
    hold(1'b1, 15);
    post("clean_pulses_a", pa - sa, 1);
    post("clean_pulses_b", pb - sb, 3);

    sa = pa; sb = pb;
    hold(1'b0, 3);
    hold(1'b1, 1);
    hold(1'b0, 2);
    hold(1'b1, 1);
    hold(1'b0, 10);
    hold(1'b1, 15);
    post("bounce_pulses_a", pa - sa, 1);
    post("bounce_pulses_b", pb - sb, 1);

    sa = pa;
    hold(1'b0, 8);
    hold(1'b1, 2);
    hold(1'b0, 8);
    hold(1'b1, 15);
    post("glitch_pulses_a", pa - sa, 1);

    sa = pa;
    en = 1'b0;
    hold(1'b0, 8);
    post("gate_level_a", int'(if_a.level), 1);
    en = 1'b1;
    hold(1'b0, 10);
    hold(1'b1, 15);
    post("gate_pulses_a", pa - sa, 0);

    hold(1'b0, 7);
    post("pre_reset_pulse_a", int'(if_a.pulse), 1);
    rst_n = 1'b0;
    #1;
    post("reset_pulse_a", int'(if_a.pulse), 0);
    post("reset_level_a", int'(if_a.level), 0);
    post("reset_state_a", int'(if_a.state), 0);
    post("reset_level_b", int'(if_b.level), 0);
    cyc(2);
    @(negedge clk);
    rst_n = 1'b1;
    sa = pa;
    cyc(12);
    post("restart_pulses_a", pa - sa, 1);
    hold(1'b1, 15);

    repeat (150) begin
      en = ($urandom_range(0, 4) != 0);
      hold(1'($urandom_range(0, 1)), $urandom_range(1, 12));
    end
    en = 1'b1;
    hold(1'b1, 15);
    cyc(2);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
